rs232in_fifo: RTL and testbench

RS232IN_FIFO -- requirements
Module: rs232in_fifo

---
 rtl/rs232_pkg.sv | 9 +
 rtl/rx_fifo_ram.sv | 17 +
 rtl/rs232in_fifo.sv | 78 +++++++
 tb/tb_rs232in_fifo.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared RX FIFO defaults and count-width rule for the RS232 peripheral
package rs232_pkg;
  localparam int RX_DEPTH_LOG2 = 4;
  localparam int RX_RTS_HIGH   = 12;
  localparam int RX_RTS_LOW    = 4;
  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction
endpackage

// File: rtl/rx_fifo_ram.sv
// rx_fifo_ram: 8-bit simple dual-port storage, synchronous write, asynchronous read
module rx_fifo_ram #(
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [2**AW];
  // write port; contents are never reset, pointers define validity
  always_ff @(posedge clock)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/rs232in_fifo.sv
// rs232in_fifo: receive byte queue with sticky overflow and optional RTS hysteresis (RS232IN_FIFO_RTS_EN)
module rs232in_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2,
  parameter int RTS_HIGH   = RX_RTS_HIGH,
  parameter int RTS_LOW    = RX_RTS_LOW
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  input  logic                                rd,
  output logic [7:0]                          rd_data,
  output logic [count_width(DEPTH_LOG2)-1:0]  count,
  output logic                                overflow,
  input  logic                                clear_overflow,
  output logic                                rts_n
);
  localparam int CW = count_width(DEPTH_LOG2);
  localparam logic [CW-1:0] FULL = CW'(1 << DEPTH_LOG2);
  if (RTS_LOW >= RTS_HIGH || RTS_HIGH > (1 << DEPTH_LOG2)) begin : g_bad_thresholds
    $error("rs232in_fifo: need RTS_LOW < RTS_HIGH <= DEPTH");
  end
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;
  logic [7:0]            ram_rdata;
  // a full queue still accepts a byte when a pop frees a slot in the same cycle
  always_comb begin
    pop        = rd && count_q != '0;
    push       = in_valid && (count_q != FULL || pop);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    overflow_d = (in_valid && !push) ? 1'b1 : clear_overflow ? 1'b0 : overflow_q;
  end
  // pointer, level and overflow state
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  rx_fifo_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clock (clock),
    .we    (push),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );
  // an empty queue shows zero so reset leaves rd_data clean despite unreset storage
  assign rd_data  = count_q == '0 ? 8'h00 : ram_rdata;
  assign count    = count_q;
  assign overflow = overflow_q;
`ifdef RS232IN_FIFO_RTS_EN
  localparam logic [CW-1:0] HI = CW'(RTS_HIGH);
  localparam logic [CW-1:0] LO = CW'(RTS_LOW);
  logic rts_n_q, rts_n_d;
  // throttle at the high mark, release at the low mark, hold in between
  always_comb rts_n_d = count_q >= HI ? 1'b1 : count_q <= LO ? 1'b0 : rts_n_q;
  // registered flow-control output
  always_ff @(posedge clock or posedge rst)
    if (rst) rts_n_q <= 1'b0;
    else rts_n_q <= rts_n_d;
  assign rts_n = rts_n_q;
`else
  assign rts_n = 1'b0;
`endif
endmodule

// File: tb/tb_rs232in_fifo.sv
// tb_rs232in_fifo: directed self-checking bench for rs232in_fifo
module tb_rs232in_fifo;
`ifdef RS232IN_FIFO_RTS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       rd = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       overflow;
  logic       rts_n;
  int vectors = 0;
  int miscompares = 0;

  rs232in_fifo dut (
    .clock          (clock),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .rd             (rd),
    .rd_data        (rd_data),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .rts_n          (rts_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    in_valid = v;
    in_data = d;
    rd = r;
    clear_overflow = c;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    rd = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_rts", 16'(rts_n), 16'd0);
    chk("rst_rdata", 16'(rd_data), 16'h00);
    rst = 1'b0;
    step(1, 8'h41, 0, 0);
    chk("first_push_count", 16'(count), 16'd1);
    chk("first_push_rdata", 16'(rd_data), 16'h41);
    step(1, 8'h42, 0, 0);
    step(1, 8'h43, 0, 0);
    chk("abc_count", 16'(count), 16'd3);
    step(0, 8'h00, 1, 0);
    chk("pop1_rdata", 16'(rd_data), 16'h42);
    chk("pop1_count", 16'(count), 16'd2);
    step(0, 8'h00, 1, 0);
    chk("pop2_rdata", 16'(rd_data), 16'h43);
    step(0, 8'h00, 1, 0);
    chk("pop3_count", 16'(count), 16'd0);
    chk("abc_ovf", 16'(overflow), 16'd0);
    step(0, 8'h00, 1, 0);
    chk("empty_pop_count", 16'(count), 16'd0);
    chk("empty_pop_ovf", 16'(overflow), 16'd0);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      chk("fill_count", 16'(count), 16'(i + 1));
      chk("fill_rts", 16'(rts_n), 16'(EN && i >= 12));
    end
    chk("fill_head", 16'(rd_data), 16'h00);
    chk("fill_ovf", 16'(overflow), 16'd0);
    step(1, 8'hFF, 0, 0);
    chk("drop_count", 16'(count), 16'd16);
    chk("drop_ovf", 16'(overflow), 16'd1);
    chk("drop_head", 16'(rd_data), 16'h00);
    step(1, 8'hEE, 0, 1);
    chk("clear_vs_drop_ovf", 16'(overflow), 16'd1);
    chk("clear_vs_drop_count", 16'(count), 16'd16);
    step(0, 8'h00, 0, 1);
    chk("clear_ovf", 16'(overflow), 16'd0);
    step(1, 8'h55, 1, 0);
    chk("full_pushpop_count", 16'(count), 16'd16);
    chk("full_pushpop_ovf", 16'(overflow), 16'd0);
    chk("full_pushpop_head", 16'(rd_data), 16'h01);
    chk("full_pushpop_rts", 16'(rts_n), 16'(EN));
    for (int j = 1; j <= 16; j++) begin
      chk("drain_rdata", 16'(rd_data), j < 16 ? 16'(j) : 16'h55);
      step(0, 8'h00, 1, 0);
      chk("drain_count", 16'(count), 16'(16 - j));
      chk("drain_rts", 16'(rts_n), 16'(EN && j < 13));
    end
    chk("drain_ovf", 16'(overflow), 16'd0);
    step(1, 8'h80, 0, 0);
    step(1, 8'h81, 0, 0);
    for (int i = 2; i < 40; i++) begin
      chk("wrap_rdata", 16'(rd_data), 16'(8'h80 + i - 2));
      step(1, 8'(8'h80 + i), 1, 0);
      chk("wrap_count", 16'(count), 16'd2);
    end
    chk("wrap_tail0", 16'(rd_data), 16'h A6);
    step(0, 8'h00, 1, 0);
    chk("wrap_tail1", 16'(rd_data), 16'hA7);
    step(0, 8'h00, 1, 0);
    chk("wrap_empty", 16'(count), 16'd0);
    for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0);
    chk("mid_fill_count", 16'(count), 16'd7);
    chk("mid_fill_head", 16'(rd_data), 16'h60);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 16'(count), 16'd0);
    chk("async_rst_rdata", 16'(rd_data), 16'h00);
    chk("async_rst_rts", 16'(rts_n), 16'd0);
    @(posedge clock);
    #1 rst = 1'b0;
    step(1, 8'h99, 0, 0);
    chk("post_rst_count", 16'(count), 16'd1);
    chk("post_rst_rdata", 16'(rd_data), 16'h99);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
